// File: rtl/fmul_pkg.sv
// Shared types and constants for the FPU multiplier pipeline stages.
package fmul_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 10;
  localparam int FRAC_W = 26;

  localparam logic [7:0] EXP_INF = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_sum;
    logic [FRAC_W-1:0] frac;
    logic              zero;
  } fmul_prod_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } skid_state_t;

endpackage

// File: rtl/fmul_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready depends only on registered state,
// so upstream never sees a combinational path from out_ready.
module fmul_skid_buf
  import fmul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // The skid entry is only ever filled from ONE, and drained into main from FULL.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= BUF_EMPTY;
      out_data  <= '0;
      skid_data <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && drain) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= BUF_FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= BUF_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= BUF_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/fmul_norm_stage.sv
// Multiplier final stage: normalise, re-bias, saturate and pack to binary32.
// Define FMUL_EXC_FLAG_EN to add registered ovf/udf exception outputs.
module fmul_norm_stage #(
  parameter int BIAS   = fmul_pkg::BIAS,
  parameter int EXP_W  = fmul_pkg::EXP_W,
  parameter int FRAC_W = fmul_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp_sum,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       y
`ifdef FMUL_EXC_FLAG_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  import fmul_pkg::*;

`ifdef FMUL_EXC_FLAG_EN
  localparam int PW = 34;
`else
  localparam int PW = 32;
`endif

  localparam logic signed [EXP_W:0] BIAS_E   = (EXP_W+1)'(BIAS);
  localparam logic signed [EXP_W:0] EXP_TOP  = (EXP_W+1)'(255);
  localparam logic signed [EXP_W:0] EXP_ZERO = '0;

  logic signed [EXP_W:0] exp_adj;
  logic [22:0]           mant;
  fp32_t                 packed_y;
  logic                  is_ovf;
  logic                  is_udf;
  logic [PW-1:0]         pay_in;
  logic [PW-1:0]         pay_out;
  logic                  unused_frac_lsb;

  assign unused_frac_lsb = in_frac[0];

  // Exponent is widened by one signed bit so underflow and overflow never wrap.
  always_comb begin
    exp_adj  = $signed({1'b0, in_exp_sum}) - BIAS_E
             + $signed({{EXP_W{1'b0}}, in_frac[FRAC_W-1]});
    mant     = in_frac[FRAC_W-1] ? in_frac[FRAC_W-2 -: 23] : in_frac[FRAC_W-3 -: 23];
    is_ovf   = 1'b0;
    is_udf   = 1'b0;
    packed_y = '{sign: in_sign, exp: 8'h00, mant: 23'h0};
    if (!in_zero) begin
      if (exp_adj <= EXP_ZERO) begin
        is_udf = 1'b1;
      end else if (exp_adj >= EXP_TOP) begin
        is_ovf       = 1'b1;
        packed_y.exp = EXP_INF;
      end else begin
        packed_y.exp  = exp_adj[7:0];
        packed_y.mant = mant;
      end
    end
  end

`ifdef FMUL_EXC_FLAG_EN
  assign pay_in = {is_ovf, is_udf, packed_y};
  assign ovf    = pay_out[33];
  assign udf    = pay_out[32];
`else
  assign pay_in = packed_y;
  logic unused_flags;
  assign unused_flags = is_ovf | is_udf;
`endif

  assign y = pay_out[31:0];

  fmul_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

endmodule
